// File: rtl/vga_fb_scheduler_if.sv
// vga_fb_scheduler_if: host access bus into the framebuffer scheduler
interface vga_fb_scheduler_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  modport master (output host_req, host_we, host_addr, host_wdata, input host_gnt, host_rdata, host_rvalid);
  modport slave (input host_req, host_we, host_addr, host_wdata, output host_gnt, host_rdata, host_rvalid);
endinterface

// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: shares one framebuffer RAM between display prefetch and a host port; VGA_FB_HOST_READ_EN enables host reads
module vga_fb_scheduler #(
  parameter int H_PIXELS     = 500,
  parameter int V_PIXELS     = 250,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 15,
  parameter int FIFO_DEPTH   = 4,
  parameter int URGENT_LVL   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_sync,
  input  logic                          pix_req,
  output logic [PIX_W-1:0]              pix_out,
  output logic                          pix_valid,
  output logic                          underrun,
  vga_fb_scheduler_if.slave             host,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [PIX_W*PIX_PER_WORD-1:0] mem_wdata,
  input  logic [PIX_W*PIX_PER_WORD-1:0] mem_rdata
);
  localparam int DW          = PIX_W * PIX_PER_WORD;
  localparam int FRAME_WORDS = H_PIXELS * V_PIXELS / PIX_PER_WORD;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int SUB_W       = $clog2(PIX_PER_WORD);
  typedef enum logic {DONE, FILL} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [DW-1:0]     fifo_q [FIFO_DEPTH];
  logic [DW-1:0]     fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              inflight_q, inflight_d;
  logic              host_rd_q, host_rd_d;
  logic [PIX_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underrun_q, underrun_d;
  logic [CNT_W-1:0]  level;
  logic              fetch_ok, urgent, host_go, fetch_go, host_wr;
  logic              push, take, empty, pop;
  assign level    = count_q + CNT_W'(inflight_q);
  assign fetch_ok = state_q == FILL && level < CNT_W'(FIFO_DEPTH) && !frame_sync;
  assign urgent   = fetch_ok && level < CNT_W'(URGENT_LVL);
  assign host_go  = host.host_req && !urgent;
  assign fetch_go = urgent || (fetch_ok && !host.host_req);
`ifdef VGA_FB_HOST_READ_EN
  assign host_wr = host.host_we;
`else
  logic unused_we;
  assign unused_we = host.host_we;
  assign host_wr   = 1'b1;
`endif
  assign mem_en           = host_go || fetch_go;
  assign mem_we           = host_go && host_wr;
  assign mem_addr         = host_go ? host.host_addr : fetch_ptr_q;
  assign mem_wdata        = host.host_wdata;
  assign host.host_gnt    = host_go;
  assign host.host_rvalid = host_rd_q;
  assign host.host_rdata  = host_rd_q ? mem_rdata : '0;
  // read latency is one cycle, so a read in flight at frame_sync returns that same cycle and is simply not pushed
  assign push  = inflight_q && !frame_sync;
  assign take  = pix_req && !frame_sync;
  assign empty = count_q == '0;
  assign pop   = take && !empty && sub_q == SUB_W'(PIX_PER_WORD - 1);
  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;
  // next-state for frame fetch, FIFO bookkeeping and pixel unpack
  always_comb begin
    state_d     = frame_sync ? FILL : (fetch_go && fetch_ptr_q == ADDR_W'(FRAME_WORDS - 1)) ? DONE : state_q;
    fetch_ptr_d = frame_sync ? '0 : fetch_go ? fetch_ptr_q + ADDR_W'(1) : fetch_ptr_q;
    fifo_d      = fifo_q;
    if (push) fifo_d[wr_ptr_q] = mem_rdata;
    wr_ptr_d    = frame_sync ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = frame_sync ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d     = frame_sync ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    sub_d       = (frame_sync || pop) ? '0 : (take && !empty) ? sub_q + SUB_W'(1) : sub_q;
    inflight_d  = fetch_go;
    host_rd_d   = host_go && !host_wr;
    pix_valid_d = take;
    pix_out_d   = (take && !empty) ? fifo_q[rd_ptr_q][sub_q*PIX_W +: PIX_W] : '0;
    underrun_d  = underrun_q || (take && empty);
  end
  // control state and registered outputs; reset parks the frame FSM in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DONE;
      fetch_ptr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sub_q       <= '0;
      inflight_q  <= 1'b0;
      host_rd_q   <= 1'b0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sub_q       <= sub_d;
      inflight_q  <= inflight_d;
      host_rd_q   <= host_rd_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
    end
  end
  // prefetch word storage; validity is tracked by the counters, so no reset
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed stimulus, queue-based reference model and literal checks for vga_fb_scheduler
module tb_vga_fb_scheduler;
  localparam int H  = 500;
  localparam int V  = 16;
  localparam int PW = 8;
  localparam int PPW = 4;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int FW = H * V / PPW;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_sync = 1'b0;
  logic          pix_req = 1'b0;
  logic [PW-1:0] pix_out;
  logic          pix_valid, underrun, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ram [0:32767];
  int            tests = 0;
  int            fails = 0;
  bit            host_auto = 1'b0;
  bit            gnt_seen = 1'b0;
  vga_fb_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();
  vga_fb_scheduler #(.V_PIXELS(V)) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .pix_req(pix_req),
    .pix_out(pix_out), .pix_valid(pix_valid), .underrun(underrun), .host(hif),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  // single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // reference model: words fetched in address order, queued, unpacked LSB-first
  bit            m_fill, m_inf, e_pv, e_ur, e_rv;
  int            m_ptr, m_sub;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_inf_d, e_rd, m_w;
  logic [PW-1:0] e_pix;
  always @(negedge clk) begin
    int lvl;
    bit elig, disp, hst, hwr;
    if (rst) begin
      m_fill = 0; m_inf = 0; m_ptr = 0; m_sub = 0; m_q.delete();
      e_pv = 0; e_ur = 0; e_rv = 0; e_pix = '0; e_rd = '0; gnt_seen = 0;
    end else begin
      lvl  = m_q.size() + int'(m_inf);
      elig = m_fill && lvl < 4 && !frame_sync;
      disp = elig && (lvl < 2 || !hif.host_req);
      hst  = hif.host_req && !(elig && lvl < 2);
`ifdef VGA_FB_HOST_READ_EN
      hwr = hif.host_we;
`else
      hwr = 1'b1;
`endif
      chk("mem_en", mem_en, disp || hst);
      chk("host_gnt", hif.host_gnt, hst);
      if (disp || hst) begin
        chk("mem_we", mem_we, hst && hwr);
        chk("mem_addr", mem_addr, hst ? hif.host_addr : AW'(m_ptr));
        if (hst && hwr) chk("mem_wdata", mem_wdata, hif.host_wdata);
      end
      chk("pix_valid", pix_valid, e_pv);
      if (e_pv) chk("pix_out", pix_out, e_pix);
      chk("underrun", underrun, e_ur);
      chk("host_rvalid", hif.host_rvalid, e_rv);
      if (e_rv) chk("host_rdata", hif.host_rdata, e_rd);
      e_pv = pix_req && !frame_sync;
      e_pix = '0;
      if (e_pv) begin
        if (m_q.size() == 0) e_ur = 1'b1;
        else begin
          m_w = m_q[0];
          e_pix = m_w[m_sub*PW +: PW];
          m_sub++;
          if (m_sub == PPW) begin
            m_sub = 0;
            void'(m_q.pop_front());
          end
        end
      end
      if (frame_sync) begin
        m_q.delete(); m_sub = 0; m_ptr = 0; m_fill = 1;
      end else if (m_inf) m_q.push_back(m_inf_d);
      m_inf = disp;
      if (disp) begin
        m_inf_d = ram[m_ptr];
        m_ptr++;
        if (m_ptr == FW) m_fill = 0;
      end
      e_rv = hst && !hwr;
      e_rd = ram[hif.host_addr];
      gnt_seen = hif.host_gnt;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (host_auto && gnt_seen) begin
      hif.host_addr  = hif.host_addr + AW'(1);
      hif.host_wdata = hif.host_wdata + 32'd1;
    end
  endtask
  task automatic host_op(bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit ok = 0;
    hif.host_req = 1; hif.host_we = we; hif.host_addr = a; hif.host_wdata = d;
    for (int i = 0; i < 16 && !ok; i++) begin
      #1;
      if (hif.host_gnt) ok = 1;
      else tick();
    end
    chk("host_grant_wait", ok, 1);
    tick();
    hif.host_req = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
  initial begin
    int grants;
    bit seen;
    for (int i = 0; i < 32768; i++) ram[i] <= DW'(i) * 32'h01010101 + 32'h03020100;
    hif.host_req = 0; hif.host_we = 0; hif.host_addr = '0; hif.host_wdata = '0;
    repeat (3) tick();
    rst = 0;
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_host_gnt", hif.host_gnt, 0);
    chk("rst_host_rvalid", hif.host_rvalid, 0);
    chk("rst_host_rdata", hif.host_rdata, 0);
    repeat (3) begin tick(); #1; chk("done_idle", mem_en, 0); end
    tick(); frame_sync = 1;
    #1 chk("fs_no_fetch", mem_en, 0);
    tick(); frame_sync = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_en", mem_en, 1);
      chk("fill_we", mem_we, 0);
      chk("fill_addr", mem_addr, i);
      tick();
    end
    #1 chk("fill_full_idle", mem_en, 0);
    tick();
    pix_req = 1;
    hif.host_req = 1; hif.host_we = 1; hif.host_addr = 15'h7F00; hif.host_wdata = 32'hA0000000;
    host_auto = 1;
    grants = 0;
    for (int c = 0; c < 52; c++) begin
      #1;
      if (c == 1) chk("pix_w0_b0", pix_out, 8'h00);
      if (c == 2) chk("pix_w0_b1", pix_out, 8'h01);
      if (c == 5) chk("pix_w1_b0", pix_out, 8'h01);
      if (c == 12) begin
        chk("urgent_fetch_addr", mem_addr, 4);
        chk("urgent_no_gnt", hif.host_gnt, 0);
      end
      if (c == 13) chk("host_after_urgent", hif.host_gnt, 1);
      if (c >= 12 && hif.host_gnt) grants++;
      tick();
    end
    chk("host_share_3of4", grants, 30);
    chk("steady_underrun", underrun, 0);
    host_auto = 0; hif.host_req = 0; pix_req = 0;
    repeat (4) tick();
    host_op(1, 15'h1234, 32'hDEADBEEF);
    host_op(0, 15'h1234, 32'h0BADF00D);
    #1;
`ifdef VGA_FB_HOST_READ_EN
    chk("hrd_rvalid", hif.host_rvalid, 1);
    chk("hrd_rdata", hif.host_rdata, 32'hDEADBEEF);
`else
    chk("hrd_rvalid", hif.host_rvalid, 0);
    chk("hrd_as_write", ram[15'h1234], 32'h0BADF00D);
`endif
    tick(); frame_sync = 1;
    tick(); frame_sync = 0;
    tick(); rst = 1;
    tick(); tick(); rst = 0;
    #1;
    chk("midrst_idle", mem_en, 0);
    chk("midrst_pix_valid", pix_valid, 0);
    repeat (3) begin tick(); #1; chk("midrst_done", mem_en, 0); end
    tick(); frame_sync = 1; pix_req = 1;
    tick(); frame_sync = 0;
    #1;
    chk("fs_wins_valid", pix_valid, 0);
    chk("fs_wins_underrun", underrun, 0);
    tick(); pix_req = 0;
    #1;
    chk("ur_valid", pix_valid, 1);
    chk("ur_pix", pix_out, 0);
    chk("ur_set", underrun, 1);
    tick(); frame_sync = 1;
    tick(); frame_sync = 0;
    #1 chk("ur_sticky_fs", underrun, 1);
    seen = 0;
    pix_req = 1;
    for (int i = 0; i < FW * 4 + 100 && !seen; i++) begin
      tick();
      #1;
      if (mem_en && !mem_we && mem_addr == AW'(FW - 1)) seen = 1;
    end
    chk("last_fetch_seen", seen, 1);
    pix_req = 0;
    repeat (8) begin tick(); #1; chk("frame_done_idle", mem_en, 0); end
    tick(); frame_sync = 1;
    tick(); frame_sync = 0;
    #1 chk("restart_addr0", mem_addr, 0);
    tick();
    #1 chk("restart_addr1", mem_addr, 1);
    tick(); frame_sync = 1;
    #1 chk("discard_fs_idle", mem_en, 0);
    tick(); frame_sync = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("refill_en", mem_en, 1);
      chk("refill_addr", mem_addr, i);
      tick();
    end
    #1 chk("refill_full_idle", mem_en, 0);
    pix_req = 1;
    tick(); pix_req = 0;
    #1 chk("discard_first_pix", pix_out, 8'h00);
    chk("discard_ur_sticky", underrun, 1);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Framebuffer access scheduler for the VGA timing generator. It shares one single-port framebuffer RAM between two requesters: the real-time display fetch path and a host read/write port. Pixels are prefetched into a small word FIFO and unpacked one per `pix_req`. The block sits between the timing generator (which drives `pix_req` from `disp_ena` and `frame_sync` from vertical blanking) and the framebuffer RAM.

## Interface
- `H_PIXELS`, 500, visible pixels per line
- `V_PIXELS`, 250, visible lines per frame
- `PIX_W`, 8, bits per pixel
- `PIX_PER_WORD`, 4, pixels packed per RAM word, LSB-first
- `ADDR_W`, 15, RAM word address width
- `FIFO_DEPTH`, 4, prefetch FIFO depth in words
- `URGENT_LVL`, 2, level below which display fetch outranks the host
- Derived: `FRAME_WORDS = H_PIXELS*V_PIXELS/PIX_PER_WORD` (31250)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `frame_sync`  in  1  one-cycle pulse; restarts the frame fetch
- `pix_req`  in  1  consume one pixel this cycle
- `pix_out`  out  PIX_W  pixel data
- `pix_valid`  out  1  `pix_out` is valid
- `underrun`  out  1  sticky; `pix_req` arrived with the FIFO empty
- `host_req`  in  1  host access request, held until granted
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  PIX_W*PIX_PER_WORD  host write data
- `host_gnt`  out  1  one-cycle grant
- `host_rdata`  out  PIX_W*PIX_PER_WORD  host read data
- `host_rvalid`  out  1  host read data valid
- `mem_en`, `mem_we`  out  1  RAM enable and write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  PIX_W*PIX_PER_WORD  RAM write data
- `mem_rdata`  in  PIX_W*PIX_PER_WORD  RAM read data, valid 1 cycle after a read

## Operation
- **Frame FSM, `FILL`:** `fetch_ptr` < `FRAME_WORDS`, so fetches are allowed.
- **Frame FSM, `DONE`:** entered after the fetch at `FRAME_WORDS-1` is issued. No more fetches.
- **`frame_sync` effects:** sets `fetch_ptr`=0, flushes the FIFO, clears `sub`, marks any in-flight read as discard, and enters `FILL`.
- **Level:** `level` = FIFO count + in-flight display read (0/1).
- **Fetch eligible:** state is `FILL`, `level` < `FIFO_DEPTH`, and `frame_sync`=0.
- **Per-cycle arbitration**, in priority order:
  1. Fetch eligible and `level` < `URGENT_LVL`: display fetch.
  2. Else if `host_req`: host access, with `host_gnt`=1.
  3. Else if fetch eligible: display fetch.
  4. Else: RAM idle (`mem_en`=0).
- **Display fetch:** `mem_en`=1, `mem_we`=0, `mem_addr`=`fetch_ptr`, then `fetch_ptr`++. Returned data is pushed to the FIFO next cycle unless it is marked discard.
- **Host write:** `mem_en`=`mem_we`=1, driven from `host_addr` and `host_wdata`.
- **Host read:** `host_rvalid`=1 with `host_rdata`=`mem_rdata` one cycle after the grant.
- **Unpack:** on `pix_req` with the FIFO non-empty, output `head[sub*PIX_W +: PIX_W]` and increment `sub`. At `sub`=`PIX_PER_WORD-1`, pop the FIFO and wrap `sub` to 0.
- **Empty FIFO on `pix_req`:** `pix_out`=0, `pix_valid`=1, `underrun` is set, and `sub` does not advance.
- **Push and pop in the same cycle:** both occur, and the count is unchanged.
- **`frame_sync` with `pix_req` in the same cycle:** `frame_sync` wins. `pix_req` is ignored, and `underrun` is not set.
- **Mid-frame reset:** everything returns to reset values and the FSM is in `DONE` (nothing is fetched until `frame_sync`).

## Timing
- **Reset values:** all outputs are 0, FSM is `DONE`, FIFO empty, `fetch_ptr`=0, `sub`=0.
- **Pixel latency:** `pix_out` and `pix_valid` are registered and appear one cycle after `pix_req`. `pix_valid` is low otherwise.
- **Host grant:** `host_gnt` is combinational in the cycle the RAM access is issued. The host drops or changes its request after seeing the grant.
- **RAM interface:** `mem_*` outputs are combinational from the arbitration decision. Read data returns one cycle later.
- **Bandwidth:** steady display demand is 1 word per `PIX_PER_WORD` cycles. The host receives at least 3 of every 4 slots once `level` ≥ `URGENT_LVL`.
- **Underrun:** cleared only by `rst`.

## Configuration
- **`VGA_FB_HOST_READ_EN` defined:** host reads are supported as described above.
- **`VGA_FB_HOST_READ_EN` undefined:** every granted host access is a write (`host_we` is ignored). `host_rdata` is tied to 0 and `host_rvalid` stays 0.

## Test plan
- **Frame start:** `rst`, then `frame_sync`, no `pix_req` → reads at addresses 0,1,2,3 on consecutive cycles, then `mem_en`=0 with `level`=4.
- **Steady display with host:** `pix_req` held high and `host_req` held high with writes → `pix_out` sequence matches RAM bytes LSB-first. The host is granted 3 of every 4 cycles, and `underrun` stays 0.
- **Urgent priority:** FIFO level 1 with `host_req`=1 → display fetch takes the cycle, `host_gnt`=0, and the host is granted the next cycle.
- **Frame end:** after the fetch at address 31249, state is `DONE` and no further fetch is issued. `frame_sync` then restarts fetching at 0 and discards an in-flight read.
- **Underrun:** `pix_req` immediately after `frame_sync` → `pix_out`=0, `underrun`=1, and `underrun` stays set through the next `frame_sync`.
- **Host read:** host read of address 0x1234 holding 0xDEADBEEF → `host_rvalid`=1 with `host_rdata`=0xDEADBEEF one cycle after the grant. With `VGA_FB_HOST_READ_EN` undefined, the same access writes RAM instead and `host_rvalid` stays 0.
